// File: rtl/sipo18_and.sv
`default_nettype none
// ============================================================================
// Module   : sipo18_and
// Purpose  : LSB-first serial-in, parallel-out 18-bit frame receiver with a
//            VALID/ACK handshake, an all-ones detect (Z0), a one-cycle
//            restart flag (ERR) and a sticky overrun flag (OVR).
// Revision : 1.0 - initial release
// ============================================================================
module sipo18_and (
    input  logic CK,
    input  logic CD,
    input  logic SI,
    input  logic SE,
    input  logic FS,
    input  logic ACK,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q4,
    output logic Q5,
    output logic Q6,
    output logic Q7,
    output logic Q8,
    output logic Q9,
    output logic Q10,
    output logic Q11,
    output logic Q12,
    output logic Q13,
    output logic Q14,
    output logic Q15,
    output logic Q16,
    output logic Q17,
    output logic VALID,
    output logic Z0,
    output logic ERR,
    output logic OVR
);

    localparam int          N        = 18;
    localparam logic [4:0]  LAST_IDX = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t         state_q;
    logic [4:0]     cnt_q;
    logic [N-2:0]   sr_q;      // bits 0..16 of the frame being assembled
    logic [N-1:0]   word_q;    // last completed word, bit 0 = first received
    logic           valid_q;
    logic           err_q;
    logic           ovr_q;

    // Frame FSM: staging, completion, handshake and status flags.
    always_ff @(posedge CK) begin
        if (CD) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // ERR is a pulse: only the restart branch raises it.
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Bits arriving without FS are silently discarded.
                    if (SE && FS) begin
                        sr_q[0] <= SI;
                        cnt_q   <= 5'd1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (SE) begin
                        if (FS) begin
                            // Restart: partial frame dropped, held word untouched.
                            sr_q[0] <= SI;
                            cnt_q   <= 5'd1;
                            err_q   <= 1'b1;
                        end else if (cnt_q == LAST_IDX) begin
                            // 18th bit goes straight to the output word.
                            word_q  <= {SI, sr_q};
                            valid_q <= 1'b1;
                            cnt_q   <= 5'd0;
                            state_q <= S_FULL;
                        end else begin
                            sr_q[cnt_q] <= SI;
                            cnt_q       <= cnt_q + 5'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (ACK) begin
                        valid_q <= 1'b0;
                        if (SE && FS) begin
                            // Zero-bubble handoff into the next frame.
                            sr_q[0] <= SI;
                            cnt_q   <= 5'd1;
                            state_q <= S_SHIFT;
                        end else begin
                            if (SE) begin
                                ovr_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end
                    end else if (SE) begin
                        // Word still unconsumed: incoming bit is lost.
                        ovr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

    // All-ones detect decoded purely from registers.
    assign Z0    = valid_q & (&word_q);
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign OVR   = ovr_q;

    assign Q0  = word_q[0];
    assign Q1  = word_q[1];
    assign Q2  = word_q[2];
    assign Q3  = word_q[3];
    assign Q4  = word_q[4];
    assign Q5  = word_q[5];
    assign Q6  = word_q[6];
    assign Q7  = word_q[7];
    assign Q8  = word_q[8];
    assign Q9  = word_q[9];
    assign Q10 = word_q[10];
    assign Q11 = word_q[11];
    assign Q12 = word_q[12];
    assign Q13 = word_q[13];
    assign Q14 = word_q[14];
    assign Q15 = word_q[15];
    assign Q16 = word_q[16];
    assign Q17 = word_q[17];

endmodule
`default_nettype wire
